// File: rtl/seconds_bcd_timer.sv
// mm:ss BCD stopwatch advanced by synchronized rising edges of tick_in, with a
// registered 4-digit active-low multiplexed 7-segment scan.
module seconds_bcd_timer #(
    parameter int SCAN_DIV = 125000,
    parameter int SCAN_W   = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover,
    output logic [3:0] an,
    output logic [6:0] seg
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t            state, state_next;
    logic              s1, s2, s3;
    logic              tick_p;
    logic              inc;
    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_tc;
    logic [1:0]        idx, idx_next;
    logic [3:0]        digit_sel;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    // NOTE: sequential state uses <= so every flop samples pre-edge values,
    // which is what makes s1->s2->s3 a real three-stage chain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tick_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick_p = s2 & ~s3;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start && !stop) state_next = RUN;
                RUN:     if (stop)           state_next = PAUSE;
                PAUSE:   if (start && !stop) state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    assign running = (state == RUN);
    assign inc     = running & tick_p & ~clear;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            rollover <= 1'b0;
        end else begin
            rollover <= 1'b0;
            if (inc) begin
                if (sec_ones == 4'd9) begin
                    sec_ones <= 4'd0;
                    if (sec_tens == 4'd5) begin
                        sec_tens <= 4'd0;
                        if (min_ones == 4'd9) begin
                            min_ones <= 4'd0;
                            if (min_tens == 4'd5) begin
                                min_tens <= 4'd0;
                                rollover <= 1'b1;
                            end else begin
                                min_tens <= min_tens + 4'd1;
                            end
                        end else begin
                            min_ones <= min_ones + 4'd1;
                        end
                    end else begin
                        sec_tens <= sec_tens + 4'd1;
                    end
                end else begin
                    sec_ones <= sec_ones + 4'd1;
                end
            end
        end
    end

    // an/seg are loaded from the upcoming index so both always describe the same digit.
    assign scan_tc  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign idx_next = scan_tc ? idx + 2'd1 : idx;

    always_comb begin
        digit_sel = sec_ones;
        case (idx_next)
            2'd0: digit_sel = sec_ones;
            2'd1: digit_sel = sec_tens;
            2'd2: digit_sel = min_ones;
            2'd3: digit_sel = min_tens;
            default: digit_sel = sec_ones;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            an       <= 4'b1110;
            seg      <= 7'b1000000;
        end else begin
            scan_cnt <= scan_tc ? '0 : scan_cnt + SCAN_W'(1);
            idx      <= idx_next;
            an       <= ~(4'b0001 << idx_next);
            seg      <= seg_of(digit_sel);
        end
    end

endmodule

// File: tb/tb_seconds_bcd_timer.sv
// Bench for seconds_bcd_timer: hand sequences, an FSM control table, and a
// randomized phase, all checked against a seconds-count reference model.
module tb_seconds_bcd_timer;

    localparam int SCAN_DIV = 4;
    localparam int SCAN_W   = 2;

    logic       clk = 1'b0;
    logic       reset, tick_in, start, stop, clear;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, rollover;
    logic [3:0] an;
    logic [6:0] seg;

    always #5 clk = ~clk;

    seconds_bcd_timer #(.SCAN_DIV(SCAN_DIV), .SCAN_W(SCAN_W)) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .start(start), .stop(stop),
        .clear(clear), .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
        .min_tens(min_tens), .running(running), .rollover(rollover), .an(an), .seg(seg)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_pat(input int d);
        case (d)
            0: seg_pat = 7'b1000000;
            1: seg_pat = 7'b1111001;
            2: seg_pat = 7'b0100100;
            3: seg_pat = 7'b0110000;
            4: seg_pat = 7'b0011001;
            5: seg_pat = 7'b0010010;
            6: seg_pat = 7'b0000010;
            7: seg_pat = 7'b1111000;
            8: seg_pat = 7'b0000000;
            9: seg_pat = 7'b0010000;
            default: seg_pat = 7'b1111111;
        endcase
    endfunction

    function automatic int digit_of(input int secs, input int k);
        case (k)
            0: digit_of = (secs % 60) % 10;
            1: digit_of = (secs % 60) / 10;
            2: digit_of = (secs / 60) % 10;
            default: digit_of = secs / 600;
        endcase
    endfunction

    // Reference model: elapsed seconds as one integer, run mode as an int,
    // display position from the number of clock edges since reset.
    int         m_secs, m_mode, m_edges;
    bit         m_roll, h1, h2, h3;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    bit         model_ok = 1'b0;
    bit         bg_en    = 1'b0;

    always @(posedge clk) begin
        int  prev;
        bit  tp;
        int  k;
        if (!reset) begin
            m_secs = 0; m_mode = 0; m_edges = 0; m_roll = 1'b0;
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
            m_an = 4'b1110; m_seg = 7'b1000000;
            model_ok = 1'b1;
        end else begin
            prev   = m_secs;
            tp     = h2 && !h3;   // tick_in rose between the samples 3 and 2 edges ago
            m_roll = 1'b0;
            if (clear) begin
                m_secs = 0;
                m_mode = 0;
            end else begin
                if (m_mode == 1 && tp) begin
                    m_secs = (m_secs + 1) % 3600;
                    m_roll = (m_secs == 0);
                end
                if (stop) begin
                    if (m_mode == 1) m_mode = 2;
                end else if (start) begin
                    m_mode = 1;
                end
            end
            m_edges++;
            k     = (m_edges / SCAN_DIV) % 4;
            m_an  = ~(4'b0001 << k);
            m_seg = seg_pat(digit_of(prev, k));
            h3 = h2; h2 = h1; h1 = tick_in;
        end
    end

    always @(negedge clk) begin
        if (bg_en && model_ok) begin
            check("m_sec_ones", 32'(sec_ones), 32'(digit_of(m_secs, 0)));
            check("m_sec_tens", 32'(sec_tens), 32'(digit_of(m_secs, 1)));
            check("m_min_ones", 32'(min_ones), 32'(digit_of(m_secs, 2)));
            check("m_min_tens", 32'(min_tens), 32'(digit_of(m_secs, 3)));
            check("m_running",  32'(running),  32'(m_mode == 1));
            check("m_rollover", 32'(rollover), 32'(m_roll));
            check("m_an",       32'(an),       32'(m_an));
            check("m_seg",      32'(seg),      32'(m_seg));
        end
    end

    task automatic pulse(input bit s, input bit p, input bit c);
        start = s; stop = p; clear = c;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    task automatic tick();
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        tick_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [15:0] disp();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    typedef struct {
        bit s;
        bit p;
        bit c;
        bit exp_run;
    } ctl_vec_t;

    initial begin
        ctl_vec_t   vecs[$];
        logic [3:0] exp_an[4];
        logic [6:0] exp_seg[4];
        logic [3:0] prev_an;
        bit         found;

        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        vecs = '{
            '{1'b0, 1'b0, 1'b1, 1'b0},   // clear -> IDLE
            '{1'b1, 1'b1, 1'b0, 1'b0},   // start+stop in IDLE: stays
            '{1'b0, 1'b1, 1'b0, 1'b0},   // stop in IDLE: no-op
            '{1'b1, 1'b0, 1'b0, 1'b1},   // start -> RUN
            '{1'b1, 1'b0, 1'b0, 1'b1},   // start in RUN: no-op
            '{1'b1, 1'b1, 1'b0, 1'b0},   // start+stop in RUN -> PAUSE
            '{1'b0, 1'b1, 1'b0, 1'b0},   // stop in PAUSE: no-op
            '{1'b1, 1'b0, 1'b0, 1'b1},   // start in PAUSE -> RUN
            '{1'b1, 1'b0, 1'b1, 1'b0},   // clear beats start
            '{1'b1, 1'b0, 1'b0, 1'b1},
            '{0, 1, 1, 0}                // clear beats stop
        };

        reset = 1'b0; tick_in = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_digits",  32'(disp()),  32'h0000);
        check("rst_running", 32'(running), 32'd0);
        check("rst_roll",    32'(rollover), 32'd0);
        check("rst_an",      32'(an),      32'(4'b1110));
        check("rst_seg",     32'(seg),     32'(7'b1000000));
        reset = 1'b1;
        bg_en = 1'b1;

        // Ten seconds, with the last update's latency observed edge by edge.
        pulse(1, 0, 0);
        check("start_run", 32'(running), 32'd1);
        ticks(9);
        check("nine_s", 32'(disp()), 32'h0009);
        tick_in = 1'b1;
        @(negedge clk); check("lat_e1", 32'(disp()), 32'h0009);
        @(negedge clk); check("lat_e2", 32'(disp()), 32'h0009);
        tick_in = 1'b0;
        @(negedge clk); check("lat_e3", 32'(disp()), 32'h0010);
        @(negedge clk);

        // Full hour and the wrap.
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        ticks(3599);
        check("at_5959", 32'(disp()), 32'h5959);
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_wrap_roll", 32'(rollover), 32'd0);
        tick_in = 1'b0;
        @(negedge clk);
        check("wrap_digits", 32'(disp()), 32'h0000);
        check("wrap_roll",   32'(rollover), 32'd1);
        check("wrap_run",    32'(running), 32'd1);
        @(negedge clk);
        check("roll_1cyc",   32'(rollover), 32'd0);
        check("post_run",    32'(running), 32'd1);
        @(negedge clk);

        // Pause holds the count; ticks while paused are dropped.
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        ticks(7);
        check("at_0007", 32'(disp()), 32'h0007);
        pulse(0, 1, 0);
        ticks(5);
        check("pause_hold", 32'(disp()), 32'h0007);
        check("pause_run",  32'(running), 32'd0);
        pulse(1, 0, 0);
        ticks(1);
        check("resume_0008", 32'(disp()), 32'h0008);
        check("resume_run",  32'(running), 32'd1);

        // A tick landing on the stop cycle still counts.
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        tick_in = 1'b0;
        pulse(0, 1, 0);
        check("stop_tick_inc", 32'(disp()), 32'h0009);
        check("stop_tick_run", 32'(running), 32'd0);
        repeat (2) @(negedge clk);

        // clear coincident with tick_p at 12:34.
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        ticks(754);
        check("at_1234", 32'(disp()), 32'h1234);
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        tick_in = 1'b0;
        pulse(0, 0, 1);
        check("clr_tick_digits", 32'(disp()), 32'h0000);
        check("clr_tick_run",    32'(running), 32'd0);
        repeat (2) @(negedge clk);
        pulse(1, 1, 0);
        check("idle_ss_run", 32'(running), 32'd0);
        ticks(2);
        check("idle_no_count", 32'(disp()), 32'h0000);

        // Control table.
        for (int i = 0; i < vecs.size(); i++) begin
            pulse(vecs[i].s, vecs[i].p, vecs[i].c);
            check($sformatf("ctl_vec%0d", i), 32'(running), 32'(vecs[i].exp_run));
        end

        // Display scan at 12:34 (paused so the digits hold still).
        pulse(1, 0, 0);
        ticks(754);
        pulse(0, 1, 0);
        found   = 1'b0;
        prev_an = an;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (prev_an == 4'b0111 && an == 4'b1110) found = 1'b1;
            else prev_an = an;
        end
        check("scan_align", 32'(found), 32'd1);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("scan_an%0d", k),  32'(an),  32'(exp_an[k / 4]));
            check($sformatf("scan_seg%0d", k), 32'(seg), 32'(exp_seg[k / 4]));
            @(negedge clk);
        end

        // Reset mid-run drops an in-flight tick.
        pulse(1, 0, 0);
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mid_rst_digits", 32'(disp()), 32'h0000);
        check("mid_rst_run",    32'(running), 32'd0);
        check("mid_rst_an",     32'(an),  32'(4'b1110));
        check("mid_rst_seg",    32'(seg), 32'(7'b1000000));
        tick_in = 1'b0;
        repeat (2) @(negedge clk);

        // Randomized controls, ticks and occasional resets against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            clear = ($urandom_range(0, 199) == 0);
            reset = !($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        start = 1'b0; stop = 1'b0; clear = 1'b0; reset = 1'b1; tick_in = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
